// File: rtl/switch_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer per channel, a
// hold-time counter, and registered single-cycle press/release strobes.
module switch_debounce #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Release,
  output logic [NUM_SWITCHES-1:0] o_Settling
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_SWITCHES-1:0] s1;
  logic [NUM_SWITCHES-1:0] s2;
  logic [CW-1:0]           cnt [NUM_SWITCHES];

  // Two-flop synchronizer bringing the raw pins into i_Clk.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_Switch;
      s2 <= s1;
    end
  end

  // Per-channel accept logic; o_Switch itself is the STABLE_LOW/HIGH state.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Switch  <= '0;
      o_Press   <= '0;
      o_Release <= '0;
      for (int i = 0; i < NUM_SWITCHES; i++) begin
        cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_SWITCHES; i++) begin
        o_Press[i]   <= 1'b0;
        o_Release[i] <= 1'b0;
        if (s2[i] == o_Switch[i]) begin
          // Any return to the accepted level restarts timing from zero.
          cnt[i] <= CNT_ZERO;
        end else if (cnt[i] == CNT_LAST) begin
          o_Switch[i]  <= s2[i];
          o_Press[i]   <= s2[i];
          o_Release[i] <= ~s2[i];
          cnt[i]       <= CNT_ZERO;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A nonzero counter means a candidate change is being timed.
  always_comb begin
    o_Settling = '0;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      o_Settling[i] = (cnt[i] != CNT_ZERO);
    end
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Multi-channel debouncer for the Go Board push-buttons. Sits directly upstream of the switch-release LED toggle logic: it synchronizes each raw, bouncy `i_Switch_n` input into `i_Clk` and filters it. It then presents a clean level plus single-cycle press and release strobes, so downstream logic can act on `o_Release[n]` instead of doing its own edge detection on a raw pin.

## Interface
- `NUM_SWITCHES`, 4: number of independent channels; must be ≥1.
- `DEBOUNCE_LIMIT`, 250000: consecutive cycles a changed level must hold before it is accepted (10 ms at 25 MHz); must be ≥1. Counter width is `$clog2(DEBOUNCE_LIMIT+1)`.
- `i_Clk`, input, 1: single system clock; all state is updated on its rising edge.
- `i_Reset`, input, 1: asynchronous, active-high reset.
- `i_Switch`, input, `NUM_SWITCHES`: raw switch levels, asynchronous to `i_Clk`; bit n is channel n.
- `o_Switch`, output, `NUM_SWITCHES`: debounced level per channel.
- `o_Press`, output, `NUM_SWITCHES`: 1-cycle strobe when `o_Switch[n]` goes 0→1.
- `o_Release`, output, `NUM_SWITCHES`: 1-cycle strobe when `o_Switch[n]` goes 1→0.
- `o_Settling`, output, `NUM_SWITCHES`: high while channel n's counter is nonzero, meaning a candidate change is being timed.

## Operation
- Synchronizer: two flops per channel, `i_Switch[n]` → `s1[n]` → `s2[n]`. Only `s2` is used downstream.
- Per channel, a two-state FSM is encoded by `o_Switch[n]` (STABLE_LOW / STABLE_HIGH), together with a counter `cnt[n]`.
- When `s2[n] == o_Switch[n]`:
  - `cnt[n] <= 0`.
  - Any bounce back to the accepted level restarts timing from zero.
- When `s2[n] != o_Switch[n]` and `cnt[n] < DEBOUNCE_LIMIT-1`: `cnt[n] <= cnt[n]+1`.
- When `s2[n] != o_Switch[n]` and `cnt[n] == DEBOUNCE_LIMIT-1`, on the same edge:
  - `o_Switch[n] <= s2[n]` and `cnt[n] <= 0`.
  - `o_Press[n]` or `o_Release[n]` is asserted according to direction.
- Strobes:
  - Registered; high for exactly one cycle; deasserted on the following edge.
  - `o_Press[n]` and `o_Release[n]` are never high together.
- The counter saturates by construction and never exceeds `DEBOUNCE_LIMIT-1`; no wrap-around.
- Channels are fully independent. Simultaneous changes on several channels are each handled in parallel with no arbitration.
- `o_Settling[n] = (cnt[n] != 0)`, driven combinationally from the register.

## Timing
- Reset values (all bits): `s1 = s2 = 0`, `cnt = 0`, `o_Switch = 0`, `o_Press = 0`, `o_Release = 0`, `o_Settling = 0`.
  - Reset takes effect immediately, without waiting for a clock.
  - Reset is released synchronously by board design; no internal reset synchronizer.
- Latency: if `i_Switch[n]` changes before edge 1 and stays stable, `s2[n]` changes at edge 2 and `o_Switch[n]` plus its strobe update at edge `2+DEBOUNCE_LIMIT`.
  - `DEBOUNCE_LIMIT=1` gives a total latency of 3 edges.
- Glitch rejection: a differing level held for fewer than `DEBOUNCE_LIMIT` consecutive `s2` samples produces no output change and no strobe.
- Reset mid-count: the count and the accepted level are discarded.
  - If the switch is held high across reset, `o_Press[n]` fires at edge `2+DEBOUNCE_LIMIT` after reset release.
  - No strobe is produced by reset itself.
- Steady-state input produces no strobes. With a stable input the outputs are otherwise constant.

## Test plan
Use `NUM_SWITCHES=4` and `DEBOUNCE_LIMIT=4` for all scenarios.

1. **Reset values.** Assert `i_Reset` mid-simulation with `i_Switch=4'hF` → all outputs are 0 immediately. After release, `o_Press=4'hF` for exactly one cycle at edge 6, then `o_Switch=4'hF`.
2. **Clean press/release.** Set `i_Switch[0]` 0→1 and hold → `o_Switch[0]=1` and a single-cycle `o_Press[0]` at edge 6. Then 1→0 → a single-cycle `o_Release[0]` at edge 6; `o_Press` stays 0.
3. **Bounce rejection.** Toggle `i_Switch[1]` with pulses 1, 2 and 3 cycles long, separated by 1-cycle lows → `o_Switch[1]` stays 0, no strobes. `o_Settling[1]` rises and clears on each bounce.
4. **Bounce then settle.** Apply a 3-cycle high, a 1-cycle low, then a steady high → the press is accepted exactly 4 cycles after `s2` reflects the steady high.
5. **Independent channels.** Press channels 2 and 3 on the same cycle, and change channel 0 two cycles later → `o_Press[2]` and `o_Press[3]` fire together. `o_Press[0]` fires 2 cycles later, with no crosstalk.
6. **Reset mid-count.** Raise `i_Switch[0]` and assert reset at edge 4 → no strobe. After release, `o_Press[0]` fires 6 edges later.
